// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract with the carry chain cut into STAGES registered chunks.
// Optional signed-overflow output ovf is built when ADDER_PIPE_OVF_EN is defined.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  logic en;

  // Stage k consumes operands from src_*[k]; stage 0 sources the ports, others the previous stage.
  logic [WIDTH-1:0] src_x [STAGES];
  logic [WIDTH-1:0] src_y [STAGES];
  logic             src_c [STAGES];
  logic             src_v [STAGES];

  // x_reg: chunks 0..k hold sum bits, chunks above still hold operand A (skew register).
  logic [WIDTH-1:0] x_reg [STAGES];
  logic [WIDTH-1:0] y_reg [STAGES];
  logic             c_reg [STAGES];
  logic             v_reg [STAGES];

`ifdef ADDER_PIPE_OVF_EN
  logic ovf_next;
  logic ovf_reg;
`endif

  assign en        = !v_reg[STAGES-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = v_reg[STAGES-1];
  assign sum       = x_reg[STAGES-1];
  assign cout      = c_reg[STAGES-1];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [CHUNK:0]   part;
      logic [WIDTH-1:0] next_x;

      if (gi == 0) begin : g_first
        assign src_x[gi] = a;
        assign src_y[gi] = b ^ {WIDTH{sub}};
        assign src_c[gi] = sub | cin;
        assign src_v[gi] = in_valid;
      end else begin : g_link
        assign src_x[gi] = x_reg[gi-1];
        assign src_y[gi] = y_reg[gi-1];
        assign src_c[gi] = c_reg[gi-1];
        assign src_v[gi] = v_reg[gi-1];
      end

      assign part = {1'b0, src_x[gi][gi*CHUNK +: CHUNK]}
                  + {1'b0, src_y[gi][gi*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, src_c[gi]};

      always_comb begin
        next_x = src_x[gi];
        next_x[gi*CHUNK +: CHUNK] = part[CHUNK-1:0];
      end

`ifdef ADDER_PIPE_OVF_EN
      if (gi == STAGES - 1) begin : g_ovf
        // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
        assign ovf_next = part[CHUNK]
                        ^ (src_x[gi][WIDTH-1] ^ src_y[gi][WIDTH-1] ^ part[CHUNK-1]);
      end
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_reg[gi] <= 1'b0;
          x_reg[gi] <= '0;
          y_reg[gi] <= '0;
          c_reg[gi] <= 1'b0;
        end else if (en) begin
          v_reg[gi] <= src_v[gi];
          x_reg[gi] <= next_x;
          y_reg[gi] <= src_y[gi];
          c_reg[gi] <= part[CHUNK];
        end
      end
    end
  endgenerate

`ifdef ADDER_PIPE_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (en) begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe (WIDTH=32, STAGES=4): driver pushes expectations,
// a monitor pops and compares each delivered result, checks latency and stall hold.
module tb_adder_pipe;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDER_PIPE_OVF_EN
  logic         ovf;
`endif

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    bit           lat;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   out_count = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Drive one transaction from a negedge, hold it until accepted, then queue its expectation.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                      input logic tsub, input logic [W-1:0] es, input logic ec,
                      input logic eo, input bit lat, output int waits);
    bit done;
    waits = 0;
    done  = 0;
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    while (!done) begin
      #4;
      if (in_ready) begin
        done = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          errors++;
          checks++;
          $display("FAIL accept_timeout: in_ready stuck at 0 for a=%h b=%h", ta, tb_v);
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    sbq.push_back('{s: es, c: ec, o: eo, lat: lat, acc: cyc});
    $display("send a=%h b=%h cin=%0b sub=%0b -> expect sum=%h cout=%0b", ta, tb_v, tcin, tsub, es, ec);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d results never delivered, expected 0 outstanding", name, sbq.size());
    end
  endtask

  // Monitor: samples 4 time units after each negedge, i.e. just before the active edge.
  logic         hold_pending = 1'b0;
  logic [W-1:0] held_s;
  logic         held_c;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && hold_pending) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_sum", sum, held_s);
        check("hold_cout", {31'd0, cout}, {31'd0, held_c});
      end
      if (!rst && out_valid && out_ready) begin
        out_count++;
        if (sbq.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_output: got sum=%h cout=%0b, expected no result", sum, cout);
        end else begin
          e = sbq.pop_front();
          $display("recv sum=%h cout=%0b (expected sum=%h cout=%0b)", sum, cout, e.s, e.c);
          check("sum", sum, e.s);
          check("cout", {31'd0, cout}, {31'd0, e.c});
`ifdef ADDER_PIPE_OVF_EN
          check("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
          if (e.lat) check("latency", cyc - e.acc, S);
        end
      end
      hold_pending = !rst && out_valid && !out_ready;
      held_s = sum;
      held_c = cout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed vectors: a, b, cin, sub, expected sum, expected cout.
  logic [W-1:0] va [6] = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'h0000_FFFF, 32'h1234_5678, 32'h8000_0000};
  logic [W-1:0] vb [6] = '{32'd1,         32'd7, 32'd5, 32'h0000_0001, 32'h1111_1111, 32'h8000_0000};
  logic         vc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [W-1:0] ve [6] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'd2, 32'h0001_0001, 32'h2345_6789, 32'h0000_0000};
  logic         vo [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  // Signed overflow for each directed vector.
  logic         vf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int w;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_sum", sum, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) send(va[i], vb[i], vc[i], vs[i], ve[i], vo[i], vf[i], 1, w);
    idle();
    wait_empty("drain_directed");

`ifdef ADDER_PIPE_OVF_EN
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1, w);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1, w);
    idle();
    wait_empty("drain_ovf");
`endif

    // Back-to-back: in_ready must stay high, so no send may wait.
    for (int i = 0; i < 8; i++) begin
      send(i, i, 1'b0, 1'b0, 2 * i, 1'b0, 1'b0, 1, w);
      check("b2b_in_ready_waits", w, 0);
    end
    idle();
    wait_empty("drain_b2b");

    // Stall: fill the pipe with out_ready low, hold 3 cycles, release.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(32'h0101_0101 * (i + 1), 32'h00FF_00FF, 1'b0, 1'b0,
               32'h0101_0101 * (i + 1) + 32'h00FF_00FF, 1'b0, 1'b0, 0, w);
        idle();
      end
      begin
        bit got_valid;
        got_valid = 0;
        for (int k = 0; k < 20 && !got_valid; k++) begin
          @(negedge clk);
          #4;
          got_valid = out_valid;
        end
        check("stall_fill_valid", {31'd0, got_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          #4;
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_empty("drain_stall");

    // Reset with 3 transactions in flight: nothing may emerge afterwards.
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 0, w);
    send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 0, w);
    send(32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 32'h0000_3000, 1'b0, 1'b0, 0, w);
    idle();
    @(negedge clk);
    #4;
    check("inflight_out_valid", {31'd0, out_valid}, 32'd1);
    check("inflight_sum", sum, 32'h0000_0030);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_sum", sum, 32'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = out_count;
    repeat (8) @(negedge clk);
    check("post_reset_outputs", out_count - seen, 0);
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Pipe still usable after the reset.
    send(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0, 32'hEFBE_D001, 1'b0, 1'b0, 1, w);
    idle();
    wait_empty("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
